// File: rtl/sram_read_streamer.sv
// sram_read_streamer: read-side sequencer for the 4096x128 SRAM wrapper.
// A start command (base_addr, num_words) is turned into a run of single-word reads on the
// wrapper's read port. Each returned word is captured one cycle after its read into a small
// FIFO and presented downstream on a valid/ready stream, with out_last on the final word.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start                  command strobe; ignored while busy
//   base_addr, num_words   first word address and word count (0 legal, up to 4096)
//   busy, done             command in progress / one-cycle completion pulse
//   sram_re, sram_radr     wrapper read enable and address
//   sram_q                 wrapper read data, valid the cycle after sram_re
//   out_data, out_valid,
//   out_ready, out_last    downstream stream; out_last marks the final word of a command
module sram_read_streamer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 13,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_re,
  output logic [ADDR_WIDTH-1:0] sram_radr,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0]   DepthL  = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_cnt_q;
  logic [ADDR_WIDTH-1:0] radr_q;
  logic [LEN_WIDTH-1:0]  issue_rem_q;
  logic [LEN_WIDTH-1:0]  drain_rem_q;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q;
  logic [PtrW-1:0]       rptr_q;
  logic [CntW-1:0]       count_q;

  logic issue;
  logic push;
  logic pop;

  // Credit check uses registered state only, so out_ready never reaches sram_re.
  assign issue = (state_q == StRun) &&
                 (({1'b0, count_q} + {{CntW{1'b0}}, inflight_q}) < DepthL);
  // The wrapper has a fixed one-cycle latency, so a read issued last cycle lands now.
  assign push  = inflight_q;
  assign pop   = out_valid && out_ready;

  assign sram_re   = issue;
  // Address is only meaningful with re; between reads it keeps the last issued address.
  assign sram_radr = issue ? addr_cnt_q : radr_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_q[rptr_q];
  // FIFO is in order, so the head is the final word exactly when one word remains unpopped.
  assign out_last  = out_valid && (drain_rem_q == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_cnt_q  <= '0;
      radr_q      <= '0;
      issue_rem_q <= '0;
      drain_rem_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        addr_cnt_q  <= addr_cnt_q + ADDR_WIDTH'(1);
        issue_rem_q <= issue_rem_q - LEN_WIDTH'(1);
        radr_q      <= addr_cnt_q;
      end
      if (pop) begin
        drain_rem_q <= drain_rem_q - LEN_WIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_cnt_q  <= base_addr;
            issue_rem_q <= num_words;
            drain_rem_q <= num_words;
            state_q     <= (num_words != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          if (issue && (issue_rem_q == LEN_WIDTH'(1))) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && (drain_rem_q == LEN_WIDTH'(1))) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Capture FIFO; storage is reset so out_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= sram_q;
        wptr_q         <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/sram_read_streamer.md
Name: sram_read_streamer

Overview:
- Read-side sequencer for the 4096x128 SRAM wrapper.
- Takes a start command (base address, word count) and drives the wrapper's read port (re, radr).
- Captures q at the wrapper's fixed one-cycle read latency into a small FIFO.
- Presents words downstream on a valid/ready stream with a last flag; sustains 1 word/cycle under no backpressure.

Parameters:
DATA_WIDTH, 128, width of sram_q / out_data
ADDR_WIDTH, 12, SRAM word address width (4096 words)
LEN_WIDTH, 13, width of num_words (0..4096)
FIFO_DEPTH, 3, capture FIFO entries; must be >=3 for full throughput, >=1 legal

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled on rising edge; ignored while busy=1
base_addr  in  ADDR_WIDTH  first word address
num_words  in  LEN_WIDTH  words to read; 0 legal
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
sram_re  out  1  to wrapper re
sram_radr  out  ADDR_WIDTH  to wrapper radr
sram_q  in  DATA_WIDTH  from wrapper q
out_data  out  DATA_WIDTH  FIFO head word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept
out_last  out  1  head word is final word of command

Behaviour:
- Reset, asynchronous: state=IDLE; all counters, FIFO pointers and inflight cleared.
- Outputs during reset: busy=0, done=0, sram_re=0, out_valid=0, out_last=0, sram_radr=0, out_data=0.
- Reset mid-command aborts the command. Words still in flight are discarded; nothing is replayed after reset.
- FSM states and transitions:
  - IDLE: on start, latch base_addr into addr_cnt and num_words into issue_rem and drain_rem. Go to RUN if num_words!=0, else DONE.
  - RUN: issue reads. When the last read is issued, go to DRAIN.
  - DRAIN: wait until drain_rem reaches 0, i.e. the last word's out handshake occurs. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in RUN, DRAIN and DONE; busy=0 in IDLE. A start seen while busy=1, including in DONE, is dropped.
- Issue rule:
  - sram_re = (state==RUN) && (occupancy + inflight < FIFO_DEPTH), using registered values only.
  - No combinational path from out_ready to sram_re.
  - sram_radr = addr_cnt, driven only while sram_re=1, otherwise holds its value.
  - On issue: addr_cnt increments modulo 2^ADDR_WIDTH (4095 wraps to 0), issue_rem decrements, inflight is set.
- Read latency:
  - sram_re high in cycle N means sram_q is valid in cycle N+1.
  - sram_q is written into the FIFO at the rising edge ending cycle N+1, unconditionally when inflight=1.
  - The credit rule guarantees the FIFO has space. A write while the FIFO is full is a design error; the bench asserts on it.
- Start-to-output latency: start in cycle 0 gives sram_re in cycle 1 and out_valid in cycle 3.
- Throughput: with out_ready held at 1, reads issue on consecutive cycles and out_valid stays high for num_words consecutive cycles.
- FIFO / stream rules:
  - out_valid = (occupancy != 0).
  - A handshake is out_valid && out_ready; it pops the head and decrements drain_rem.
  - A push and a pop may occur in the same cycle; occupancy is then unchanged.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - out_last=1 only on the word whose pop brings drain_rem to 0.
- done pulses in the cycle after the last handshake; busy falls in the cycle after done.
- num_words=4096 reads the full array once, starting from base_addr and wrapping.
- Word order out equals address order issued; no word is dropped or duplicated.

Test Plan:
- Burst: base=0, num_words=4, mem[i]=i, out_ready=1. Expect sram_re in cycles 1-4 with radr 0..3, out_valid in cycles 3-6 with data 0..3, out_last in cycle 6, done in cycle 7, busy low from cycle 8.
- Backpressure: base=16, num_words=8, out_ready low for cycles 4-9. Expect occupancy+inflight never above 3 and sram_re low while the FIFO is full. Output must be exactly mem[16..23] in order, with out_data stable while stalled.
- Wrap: base=4094, num_words=4. Expect radr sequence 4094, 4095, 0, 1 and data in the same order.
- Zero length: num_words=0. Expect sram_re never asserted, out_valid never asserted, done in cycle 1, busy high only in cycle 1.
- Command collision: second start in cycle 2 of a 4-word command, with different base. It is ignored; exactly 4 words are output. A new start in the IDLE cycle after busy falls is accepted.
- Reset abort: rst_n low in cycle 4 of an 8-word command. busy, out_valid and sram_re drop immediately. After release, a new command base=100, num_words=2 outputs mem[100..101] with no stale words.
